// File: rtl/reset_sequencer_if.sv
// Bundle of power-good input, per-channel requests and the sequenced domain resets.
// With SYSTEM__RST_CAUSE_EN the last-reset cause and request counter are added.
interface reset_sequencer_if #(
   parameter int Channels = 3
);
   logic                power;
   logic [Channels-1:0] req;
   logic [Channels-1:0] rst_n_out;
   logic                ready;
   logic                busy;
`ifdef SYSTEM__RST_CAUSE_EN
   logic [1:0]          cause;
   logic [7:0]          req_count;

   modport master (output power, req, input rst_n_out, ready, busy, cause, req_count);
   modport slave  (input power, req, output rst_n_out, ready, busy, cause, req_count);
`else
   modport master (output power, req, input rst_n_out, ready, busy);
   modport slave  (input power, req, output rst_n_out, ready, busy);
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Staged multi-domain reset sequencer: power-on delay, ordered release, per-channel re-reset.
// Optional SYSTEM__RST_CAUSE_EN adds last-cause and request-count reporting.
module reset_sequencer #(
   parameter int Channels   = 3,
   parameter int PorCycles  = 16,
   parameter int StageGap   = 4,
   parameter int HoldCycles = 8
) (
   input  logic             clk,
   input  logic             rst,
   reset_sequencer_if.slave bus
);

   localparam int MaxPg  = (PorCycles > StageGap) ? PorCycles : StageGap;
   localparam int MaxCyc = (MaxPg > HoldCycles) ? MaxPg : HoldCycles;
   localparam int CntW   = $clog2(MaxCyc + 1);
   localparam int IdxW   = (Channels > 1) ? $clog2(Channels) : 1;

   localparam logic [CntW-1:0] CntZero  = CntW'(0);
   localparam logic [CntW-1:0] CntOne   = CntW'(1);
   localparam logic [CntW-1:0] PorLoad  = CntW'(PorCycles - 1);
   localparam logic [CntW-1:0] GapLoad  = CntW'(StageGap - 1);
   localparam logic [CntW-1:0] HoldLoad = CntW'(HoldCycles - 1);
   localparam logic [IdxW-1:0] IdxZero  = IdxW'(0);
   localparam logic [IdxW-1:0] IdxOne   = IdxW'(1);
   localparam logic [IdxW-1:0] LastIdx  = IdxW'(Channels - 1);

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_POR     = 3'd1,
      ST_RELEASE = 3'd2,
      ST_RUN     = 3'd3,
      ST_HOLD    = 3'd4
   } state_e;

   // idx is the next channel to release in RELEASE and the restart channel in HOLD
   typedef struct packed {
      state_e              state;
      logic [CntW-1:0]     cnt;
      logic [IdxW-1:0]     idx;
      logic [Channels-1:0] rst_n;
      logic                ready;
      logic                busy;
   } seq_t;

   localparam seq_t SeqReset = '{
      state: ST_OFF,
      cnt:   CntZero,
      idx:   IdxZero,
      rst_n: {Channels{1'b0}},
      ready: 1'b0,
      busy:  1'b1
   };

   function automatic logic [IdxW-1:0] lowest_set(input logic [Channels-1:0] v);
      logic [IdxW-1:0] idx;
      idx = IdxZero;
      for (int i = Channels - 1; i >= 0; i--) begin
         idx = v[i] ? IdxW'(i) : idx;
      end
      return idx;
   endfunction

   function automatic logic [Channels-1:0] mask_from(input logic [IdxW-1:0] m);
      logic [Channels-1:0] mask;
      for (int i = 0; i < Channels; i++) begin
         mask[i] = (i >= int'(m));
      end
      return mask;
   endfunction

   function automatic logic [IdxW-1:0] min_idx(input logic [IdxW-1:0] a, input logic [IdxW-1:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic seq_t release_ch(input seq_t cur, input logic [IdxW-1:0] ch);
      seq_t r;
      r           = cur;
      r.rst_n[ch] = 1'b1;
      r.cnt       = GapLoad;
      r.idx       = ch + IdxOne;
      r.state     = (ch == LastIdx) ? ST_RUN : ST_RELEASE;
      r.ready     = (ch == LastIdx);
      r.busy      = (ch != LastIdx);
      return r;
   endfunction

   function automatic seq_t enter_hold(input seq_t cur, input logic [IdxW-1:0] low,
                                       input logic [IdxW-1:0] start);
      seq_t r;
      r       = cur;
      r.rst_n = cur.rst_n & ~mask_from(low);
      r.state = ST_HOLD;
      r.cnt   = HoldLoad;
      r.idx   = start;
      r.ready = 1'b0;
      r.busy  = 1'b1;
      return r;
   endfunction

   logic            sync1_q;
   logic            sync2_q;
   seq_t            cur_q;
   seq_t            nxt_d;
   logic            req_any;
   logic [IdxW-1:0] req_low;

   // two-flop synchroniser for the asynchronous power-good input
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.power;
         sync2_q <= sync1_q;
      end
   end

   // next-state and registered-output computation; power loss beats any request
   always_comb begin
      req_any     = |bus.req;
      req_low     = lowest_set(bus.req);
      nxt_d       = cur_q;
      nxt_d.ready = 1'b0;
      nxt_d.busy  = 1'b1;
      if (!sync2_q) begin
         nxt_d = SeqReset;
      end else begin
         case (cur_q.state)
            ST_OFF: begin
               nxt_d.state = ST_POR;
               nxt_d.cnt   = PorLoad;
               nxt_d.rst_n = {Channels{1'b0}};
            end
            ST_POR: begin
               if (cur_q.cnt == CntZero) begin
                  nxt_d = release_ch(cur_q, IdxZero);
               end else begin
                  nxt_d.cnt = cur_q.cnt - CntOne;
               end
            end
            ST_RELEASE: begin
               if (req_any) begin
                  nxt_d = enter_hold(cur_q, req_low, min_idx(req_low, cur_q.idx));
               end else if (cur_q.cnt == CntZero) begin
                  nxt_d = release_ch(cur_q, cur_q.idx);
               end else begin
                  nxt_d.cnt = cur_q.cnt - CntOne;
               end
            end
            ST_RUN: begin
               if (req_any) begin
                  nxt_d = enter_hold(cur_q, req_low, req_low);
               end else begin
                  nxt_d.ready = 1'b1;
                  nxt_d.busy  = 1'b0;
               end
            end
            ST_HOLD: begin
               if (req_any) begin
                  nxt_d = enter_hold(cur_q, req_low, min_idx(req_low, cur_q.idx));
               end else if (cur_q.cnt == CntZero) begin
                  nxt_d = release_ch(cur_q, cur_q.idx);
               end else begin
                  nxt_d.cnt = cur_q.cnt - CntOne;
               end
            end
            default: begin
               nxt_d = SeqReset;
            end
         endcase
      end
   end

   // sequencer state and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_q <= SeqReset;
      end else begin
         cur_q <= nxt_d;
      end
   end

   assign bus.rst_n_out = cur_q.rst_n;
   assign bus.ready     = cur_q.ready;
   assign bus.busy      = cur_q.busy;

`ifdef SYSTEM__RST_CAUSE_EN
   logic [1:0] cause_q;
   logic [1:0] cause_d;
   logic [7:0] req_count_q;
   logic [7:0] req_count_d;
   logic       pf_q;
   logic       pf_d;
   logic       active_s;

   // pf remembers whether the last exit from an operating state was a power failure
   always_comb begin
      active_s    = (cur_q.state == ST_RUN) || (cur_q.state == ST_RELEASE) ||
                    (cur_q.state == ST_HOLD);
      cause_d     = cause_q;
      req_count_d = req_count_q;
      if ((cur_q.state != ST_POR) && (nxt_d.state == ST_POR)) begin
         cause_d = pf_q ? 2'd3 : 2'd1;
      end else if (((cur_q.state == ST_RUN) || (cur_q.state == ST_RELEASE)) &&
                   (nxt_d.state == ST_HOLD)) begin
         cause_d     = 2'd2;
         req_count_d = (req_count_q == 8'hFF) ? req_count_q : req_count_q + 8'd1;
      end else begin
         cause_d = cause_q;
      end
      if (active_s && (nxt_d.state != cur_q.state)) begin
         pf_d = (nxt_d.state == ST_OFF);
      end else begin
         pf_d = pf_q;
      end
   end

   // reset-cause reporting registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cause_q     <= 2'd0;
         req_count_q <= 8'd0;
         pf_q        <= 1'b0;
      end else begin
         cause_q     <= cause_d;
         req_count_q <= req_count_d;
         pf_q        <= pf_d;
      end
   end

   assign bus.cause     = cause_q;
   assign bus.req_count = req_count_q;
`endif

endmodule
